// File: rtl/wb_out_arbiter.sv
// wb_out_arbiter
// Merges the result streams of N_LANE writeback lanes onto one valid/ready
// output port. Each lane feeds its own small FIFO, and a registered per-lane
// stall throttles the lane before its FIFO fills. The output register is
// granted round-robin across non-empty FIFOs. A run is sequenced as
// IDLE -> RUN (wait for end_op from every enabled lane) -> DRAIN (empty all
// buffering) -> DONE (one-cycle all_done) -> IDLE.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle run start, honoured only while idle
//   lane_en       participating lanes, captured on the accepted start
//   in_data       lane i beat at [i*data_width +: data_width]
//   in_valid      lane i beat present
//   lane_end_op   lane i end-of-operation pulse
//   stall         registered back-pressure per lane
//   m_data/m_src  output beat and its source lane
//   m_valid       output beat valid, held until m_ready
//   m_ready       downstream accept
//   all_done      one-cycle pulse closing a run
//   busy          run in progress
//   ovf_err       sticky: a beat was dropped at a full FIFO
module wb_out_arbiter #(
    parameter int data_width = 32,
    parameter int N_LANE     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_LANE-1:0]            lane_en,
    input  logic [data_width*N_LANE-1:0] in_data,
    input  logic [N_LANE-1:0]            in_valid,
    input  logic [N_LANE-1:0]            lane_end_op,
    output logic [N_LANE-1:0]            stall,
    output logic [data_width-1:0]        m_data,
    output logic [$clog2(N_LANE)-1:0]    m_src,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         all_done,
    output logic                         busy,
    output logic                         ovf_err
);

    localparam int SRC_W = $clog2(N_LANE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q;
    logic [N_LANE-1:0]       lane_en_q;
    logic [N_LANE-1:0]       end_seen_q;
    logic [SRC_W-1:0]        rr_q;
    logic [N_LANE-1:0]       stall_q;
    logic                    m_valid_q;
    logic [data_width-1:0]   m_data_q;
    logic [SRC_W-1:0]        m_src_q;
    logic                    all_done_q;
    logic                    busy_q;
    logic                    ovf_q;

    logic [data_width-1:0]   mem_q    [N_LANE][FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q [N_LANE];
    logic [PTR_W-1:0]        rd_ptr_q [N_LANE];
    logic [CNT_W-1:0]        cnt_q    [N_LANE];
    logic [CNT_W-1:0]        cnt_d    [N_LANE];

    logic                    accepting;
    logic                    load;
    logic                    fifos_empty;
    logic [N_LANE-1:0]       ends_now;
    logic [N_LANE-1:0]       nonempty;
    logic [N_LANE-1:0]       wr_req;
    logic [N_LANE-1:0]       push;
    logic [N_LANE-1:0]       pop;
    logic [N_LANE-1:0]       ovf_hit;
    logic                    gnt_found;
    logic [SRC_W-1:0]        gnt_idx;

    // Lane index base+k, wrapping at N_LANE (which need not be a power of 2).
    function automatic logic [SRC_W-1:0] lane_wrap(input logic [SRC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_LANE) s = s - N_LANE;
        return SRC_W'(s);
    endfunction

    assign accepting   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign load        = !m_valid_q || m_ready;
    assign fifos_empty = ~|nonempty;
    assign ends_now    = lane_end_op & lane_en_q;

    // Round-robin grant: scanning from the far end down lets the lane
    // closest to rr_q overwrite earlier hits, so it wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = N_LANE - 1; k >= 0; k--) begin
            if (nonempty[lane_wrap(rr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = lane_wrap(rr_q, k);
            end
        end
    end

    // A full FIFO may still accept a beat when it pops in the same cycle.
    always_comb begin
        nonempty = '0;
        wr_req   = '0;
        push     = '0;
        pop      = '0;
        ovf_hit  = '0;
        for (int i = 0; i < N_LANE; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            wr_req[i]   = accepting && lane_en_q[i] && in_valid[i];
            pop[i]      = load && gnt_found && (gnt_idx == SRC_W'(i));
            push[i]     = wr_req[i] && ((cnt_q[i] != CNT_W'(FIFO_DEPTH)) || pop[i]);
            ovf_hit[i]  = wr_req[i] && (cnt_q[i] == CNT_W'(FIFO_DEPTH)) && !pop[i];
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end
    end

    // FIFO storage (no reset needed; occupancy counters qualify contents)
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANE; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i*data_width +: data_width];
            end
        end
    end

    // Control: FIFO pointers, output register, run sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lane_en_q  <= '0;
            end_seen_q <= '0;
            rr_q       <= '0;
            stall_q    <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_src_q    <= '0;
            all_done_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < N_LANE; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LANE; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                // Two slots of headroom cover beats already in flight in the lane.
                stall_q[i] <= lane_en_q[i] && (cnt_d[i] >= CNT_W'(FIFO_DEPTH - 2));
            end

            if (load) begin
                m_valid_q <= gnt_found;
                if (gnt_found) begin
                    m_data_q <= mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
                    m_src_q  <= gnt_idx;
                    rr_q     <= lane_wrap(gnt_idx, 1);
                end
            end

            if (|ovf_hit) ovf_q <= 1'b1;

            all_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        lane_en_q  <= lane_en;
                        end_seen_q <= '0;
                        ovf_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    end_seen_q <= end_seen_q | ends_now;
                    if (((end_seen_q | ends_now) & lane_en_q) == lane_en_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty buffers, nothing arriving, and the output register
                    // either idle or handing off its last beat this cycle.
                    if (fifos_empty && !(|wr_req) && load) begin
                        state_q    <= S_DONE;
                        all_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall    = stall_q;
    assign m_data   = m_data_q;
    assign m_src    = m_src_q;
    assign m_valid  = m_valid_q;
    assign all_done = all_done_q;
    assign busy     = busy_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_wb_out_arbiter.sv
// Testbench for wb_out_arbiter: directed scenarios followed by randomized
// runs, every cycle compared against a queue-based reference model.
module tb_wb_out_arbiter;

    localparam int DW    = 32;
    localparam int NL    = 4;
    localparam int DEPTH = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NL-1:0]     lane_en;
    logic [DW*NL-1:0]  in_data;
    logic [NL-1:0]     in_valid;
    logic [NL-1:0]     lane_end_op;
    logic [NL-1:0]     stall;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_src;
    logic              m_valid;
    logic              m_ready;
    logic              all_done;
    logic              busy;
    logic              ovf_err;

    always #5 clk = ~clk;

    wb_out_arbiter #(.data_width(DW), .N_LANE(NL), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lane_en     (lane_en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .lane_end_op (lane_end_op),
        .stall       (stall),
        .m_data      (m_data),
        .m_src       (m_src),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .all_done    (all_done),
        .busy        (busy),
        .ovf_err     (ovf_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-lane arrays used as queues (head at index 0).
    int            ph;
    logic [NL-1:0] en_r;
    logic [NL-1:0] seen;
    int            rr;
    logic [DW-1:0] mq [NL][DEPTH];
    int            mcnt [NL];
    logic          mv;
    logic [DW-1:0] md;
    int            msrc;
    logic [NL-1:0] mstall;
    logic          mdone;
    logic          mbusy;
    logic          movf;

    function automatic void model_step();
        int            g;
        int            l;
        bit            take;
        bit            all_empty;
        logic [NL-1:0] req;
        logic [NL-1:0] en_old;
        if (rst) begin
            ph = PH_IDLE; en_r = '0; seen = '0; rr = 0;
            mv = 1'b0; md = '0; msrc = 0; mstall = '0;
            mdone = 1'b0; mbusy = 1'b0; movf = 1'b0;
            for (int i = 0; i < NL; i++) mcnt[i] = 0;
            return;
        end
        en_old = en_r;
        take   = !mv || m_ready;
        g      = -1;
        if (take) begin
            for (int k = 0; k < NL; k++) begin
                l = (rr + k) % NL;
                if (g < 0 && mcnt[l] > 0) g = l;
            end
        end
        all_empty = 1'b1;
        for (int i = 0; i < NL; i++) if (mcnt[i] != 0) all_empty = 1'b0;
        req = (ph == PH_RUN || ph == PH_DRAIN) ? (en_r & in_valid) : '0;

        case (ph)
            PH_IDLE: if (start) begin
                ph = PH_RUN; en_r = lane_en; seen = '0; movf = 1'b0;
            end
            PH_RUN: begin
                seen = seen | (lane_end_op & en_r);
                if ((seen & en_r) == en_r) ph = PH_DRAIN;
            end
            PH_DRAIN: if (all_empty && req == '0 && take) ph = PH_DONE;
            default: ph = PH_IDLE;
        endcase

        if (take) begin
            if (g >= 0) begin
                mv = 1'b1; md = mq[g][0]; msrc = g;
                for (int j = 0; j < DEPTH - 1; j++) mq[g][j] = mq[g][j+1];
                mcnt[g] = mcnt[g] - 1;
                rr = (g + 1) % NL;
            end else begin
                mv = 1'b0;
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (req[i]) begin
                if (mcnt[i] < DEPTH) begin
                    mq[i][mcnt[i]] = in_data[i*DW +: DW];
                    mcnt[i] = mcnt[i] + 1;
                end else begin
                    movf = 1'b1;
                end
            end
        end
        for (int i = 0; i < NL; i++) mstall[i] = en_old[i] && (mcnt[i] >= DEPTH - 2);
        mdone = (ph == PH_DONE);
        mbusy = (ph != PH_IDLE);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("m_valid",  m_valid,  mv);
        check_eq("m_data",   m_data,   md);
        check_eq("m_src",    m_src,    msrc);
        check_eq("stall",    stall,    mstall);
        check_eq("all_done", all_done, mdone);
        check_eq("busy",     busy,     mbusy);
        check_eq("ovf_err",  ovf_err,  movf);
    endtask

    task automatic set_beat(input int lane, input logic [DW-1:0] v);
        in_data[lane*DW +: DW] = v;
        in_valid[lane] = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int pulses;
        pulses = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (all_done) pulses++;
            if (!busy && pulses > 0) break;
        end
        check_eq({tag, "_done_pulses"}, pulses, 1);
        check_eq({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        logic [NL-1:0] run_en;
        logic [NL-1:0] ended;
        int            pick;

        rst = 1'b1; start = 1'b0; lane_en = '0; in_data = '0;
        in_valid = '0; lane_end_op = '0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_busy",    busy,    0);
        check_eq("rst_stall",   stall,   0);
        check_eq("rst_ovf",     ovf_err, 0);

        // One beat per lane on the same cycle -> sources 0,1,2,3 in turn.
        lane_en = 4'hF; start = 1'b1; tick(); start = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < NL; i++) set_beat(i, 32'hA0 + i);
        tick(); in_valid = '0;
        for (int k = 0; k < NL; k++) begin
            tick();
            check_eq("rr_src",  m_src,  k);
            check_eq("rr_data", m_data, 32'hA0 + k);
        end
        tick();

        // Lane 2 streams 8 beats while the output is blocked.
        m_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            set_beat(2, 32'hB0 + b); tick(); in_valid = '0;
        end
        check_eq("burst_stall2", stall[2], 1);
        check_eq("burst_ovf",    ovf_err,  0);
        check_eq("burst_head",   m_data,   32'hB0);
        m_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            check_eq("burst_order", m_data, 32'hB0 + k);
            check_eq("burst_src",   m_src,  2);
        end
        tick();

        // Occupy the output with lane 0, then overflow lane 1 while holding.
        m_ready = 1'b0;
        set_beat(0, 32'hC0); tick(); in_valid = '0;
        tick();
        for (int b = 0; b < 10; b++) begin
            set_beat(1, 32'hD0 + b); tick(); in_valid = '0;
            check_eq("hold_data", m_data, 32'hC0);
            check_eq("hold_src",  m_src,  0);
        end
        check_eq("ovf_set", ovf_err, 1);
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("ovf_src",  m_src,  1);
            check_eq("ovf_data", m_data, 32'hD0 + k);
        end
        tick();
        check_eq("ovf_dropped", m_valid, 0);
        lane_end_op = 4'hF; tick(); lane_end_op = '0;
        wait_done(20, "run1");

        // Completion with lanes 0 and 2 enabled.
        lane_en = 4'b0101; start = 1'b1; tick(); start = 1'b0;
        check_eq("run2_ovf_cleared", ovf_err, 0);
        m_ready = 1'b0;
        set_beat(0, 32'hE0); set_beat(2, 32'hE2); set_beat(1, 32'hEE);
        tick(); in_valid = '0;
        set_beat(0, 32'hE1); tick(); in_valid = '0;
        lane_end_op = 4'b0011; tick(); lane_end_op = '0;
        tick(); tick();
        lane_end_op = 4'b0100; tick(); lane_end_op = '0;
        check_eq("run2_busy_pending", busy,     1);
        check_eq("run2_no_early",     all_done, 0);
        m_ready = 1'b1;
        wait_done(40, "run2");

        // Empty run: all_done on the third cycle of the run.
        lane_en = '0; start = 1'b1; tick(); start = 1'b0;
        check_eq("empty_c1", all_done, 0);
        tick(); check_eq("empty_c2", all_done, 0);
        tick(); check_eq("empty_c3", all_done, 1);
        tick(); check_eq("empty_c4", all_done, 0);
        check_eq("empty_busy", busy, 0);

        // Start while running is ignored; reset during drain aborts the run.
        lane_en = 4'b0011; start = 1'b1; tick(); start = 1'b0;
        m_ready = 1'b0;
        set_beat(0, 32'hF0); set_beat(1, 32'hF1); tick(); in_valid = '0;
        lane_en = 4'hF; start = 1'b1; tick(); start = 1'b0;
        set_beat(3, 32'hF3); tick(); in_valid = '0;
        lane_end_op = 4'b0011; tick(); lane_end_op = '0;
        tick();
        check_eq("drain_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("abort_m_valid",  m_valid,  0);
        check_eq("abort_busy",     busy,     0);
        check_eq("abort_all_done", all_done, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("abort_no_done", all_done, 0);
        end

        // Randomized runs: lanes honour the stall (with rare violations).
        for (int r = 0; r < 6; r++) begin
            run_en  = 4'($urandom_range(1, 15));
            lane_en = run_en; start = 1'b1; tick(); start = 1'b0;
            ended = '0;
            for (int c = 0; c < 150; c++) begin
                in_valid = '0; lane_end_op = '0;
                for (int i = 0; i < NL; i++) begin
                    if (!ended[i] && $urandom_range(0, 99) < 50 &&
                        (!mstall[i] || $urandom_range(0, 99) < 8)) begin
                        set_beat(i, $urandom);
                    end
                end
                m_ready = ($urandom_range(0, 99) < 60);
                if (c == 149) begin
                    lane_end_op = run_en & ~ended;
                end else if (c > 40 && $urandom_range(0, 99) < 4 &&
                             $countones(run_en & ~ended) > 1) begin
                    pick = $urandom_range(0, NL - 1);
                    if (run_en[pick] && !ended[pick]) begin
                        lane_end_op[pick] = 1'b1;
                        ended[pick] = 1'b1;
                    end
                end
                if (ph == PH_RUN && $urandom_range(0, 99) < 3) begin
                    start = 1'b1;
                    lane_en = 4'($urandom_range(0, 15));
                end
                tick();
                start = 1'b0;
            end
            in_valid = '0; lane_end_op = '0; m_ready = 1'b1;
            wait_done(200, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
